mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 9 +
 rtl/mem_req_arbiter_beat_counter.sv | 21 ++
 rtl/mem_req_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared FSM encodings, burst length width and AXI defines
package mem_req_arbiter_pkg;
    localparam int AXLEN  = 8;
    localparam int AXSIZE = 3;
    localparam int LEN_W  = AXLEN;

    typedef enum logic [1:0] {R_IDLE, R_IC, R_DC} rd_state_t;
    typedef enum logic {W_IDLE, W_BUSY} wr_state_t;
endpackage

// File: rtl/mem_req_arbiter_beat_counter.sv
// arb_beat_counter: counts burst beats from 0 and flags the beat matching the length
module arb_beat_counter
    import mem_req_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             inc,
    input  logic [LEN_W-1:0] len,
    output logic             last
);
    logic [LEN_W-1:0] r_cnt;

    // beat count, cleared between bursts
    always_ff @(posedge clk) begin
        if (!resetn || clear) r_cnt <= '0;
        else if (inc) r_cnt <= r_cnt + 1'b1;
    end

    assign last = r_cnt == len;
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: icache/dcache read and dcache write-back arbiter onto one cache port.
// Define ARB_ROUND_ROBIN_EN for round-robin read arbitration; default is dcache priority.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter logic [LEN_W-1:0] IC_LEN = 8'd7,
    parameter int               DW     = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             ic_req,
    input  logic [DW-1:0]    ic_addr,
    output logic [DW-1:0]    ic_rdata,
    output logic             ic_rvalid,
    output logic             ic_done,
    input  logic             dc_rreq,
    input  logic [DW-1:0]    dc_raddr,
    input  logic [3:0]       dc_rsel,
    input  logic [LEN_W-1:0] dc_rlen,
    output logic [DW-1:0]    dc_rdata,
    output logic             dc_rvalid,
    output logic             dc_rdone,
    input  logic             dc_wreq,
    input  logic [DW-1:0]    dc_waddr,
    input  logic [3:0]       dc_wsel,
    input  logic [LEN_W-1:0] dc_wlen,
    input  logic [DW-1:0]    dc_wdata,
    output logic             dc_wnext,
    output logic             dc_wdone,
    output logic             cache_ce,
    output logic             cache_ren,
    output logic             cache_wen,
    output logic [DW-1:0]    cache_raddr,
    output logic [DW-1:0]    cache_waddr,
    output logic [3:0]       cache_rsel,
    output logic [3:0]       cache_wsel,
    output logic [LEN_W-1:0] cacher_burst_length,
    output logic [LEN_W-1:0] cachew_burst_length,
    output logic [DW-1:0]    cache_wdata,
    output logic             cache_wlast,
    input  logic [DW-1:0]    rdata_i,
    input  logic             rdata_valid_i,
    input  logic             wdata_resp_i
);
    rd_state_t        r_rstate, w_rstate_nxt;
    wr_state_t        r_wstate, w_wstate_nxt;
    logic [DW-1:0]    r_raddr, r_waddr;
    logic [3:0]       r_rsel, r_wsel;
    logic [LEN_W-1:0] r_rlen, r_wlen;
    logic             r_ren, r_wen;
    logic             w_rbusy, w_wbusy, w_dc_ok, w_gnt_dc, w_gnt_ic, w_rbeat, w_rlast, w_rdone;
    logic             w_wstart, w_wbeat, w_wlast, w_wdone;

    assign w_rbusy  = r_rstate != R_IDLE;
    assign w_wbusy  = r_wstate == W_BUSY;
    // a dcache read may not overtake a write-back to the same address
    assign w_dc_ok  = dc_rreq && !(w_wbusy && r_waddr == dc_raddr);
`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_ptr;
    assign w_gnt_dc = !w_rbusy && !flush && w_dc_ok && !(r_rr_ptr && ic_req);

    // pointer points at the requester that did not win the last grant
    always_ff @(posedge clk) begin
        if (!resetn) r_rr_ptr <= 1'b0;
        else if (w_gnt_dc) r_rr_ptr <= 1'b1;
        else if (w_gnt_ic) r_rr_ptr <= 1'b0;
    end
`else
    assign w_gnt_dc = !w_rbusy && !flush && w_dc_ok;
`endif
    assign w_gnt_ic = !w_rbusy && !flush && ic_req && !w_gnt_dc;
    assign w_rbeat  = w_rbusy && rdata_valid_i && !flush;
    assign w_rdone  = w_rbeat && w_rlast;
    assign w_wstart = !w_wbusy && dc_wreq;
    assign w_wbeat  = w_wbusy && wdata_resp_i;
    assign w_wdone  = w_wbeat && w_wlast;

    arb_beat_counter u_rcnt (
        .clk(clk), .resetn(resetn), .clear(!w_rbusy || flush || w_rdone),
        .inc(w_rbeat), .len(r_rlen), .last(w_rlast)
    );

    arb_beat_counter u_wcnt (
        .clk(clk), .resetn(resetn), .clear(!w_wbusy || w_wdone),
        .inc(w_wbeat), .len(r_wlen), .last(w_wlast)
    );

    // read and write next-state; flush only aborts the read side
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_wstate_nxt = r_wstate;
        if (flush || w_rdone) w_rstate_nxt = R_IDLE;
        else if (w_gnt_dc) w_rstate_nxt = R_DC;
        else if (w_gnt_ic) w_rstate_nxt = R_IC;
        if (w_wstart) w_wstate_nxt = W_BUSY;
        else if (w_wdone) w_wstate_nxt = W_IDLE;
    end

    // state registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rstate <= R_IDLE;
            r_wstate <= W_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
            r_wstate <= w_wstate_nxt;
        end
    end

    // command latches and the one-cycle request pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_raddr <= '0;
            r_rsel  <= '0;
            r_rlen  <= '0;
            r_waddr <= '0;
            r_wsel  <= '0;
            r_wlen  <= '0;
        end else begin
            r_ren <= w_gnt_dc || w_gnt_ic;
            r_wen <= w_wstart;
            if (w_gnt_dc) begin
                r_raddr <= dc_raddr;
                r_rsel  <= dc_rsel;
                r_rlen  <= dc_rlen;
            end else if (w_gnt_ic) begin
                r_raddr <= ic_addr;
                r_rsel  <= 4'b1111;
                r_rlen  <= IC_LEN;
            end
            if (w_wstart) begin
                r_waddr <= dc_waddr;
                r_wsel  <= dc_wsel;
                r_wlen  <= dc_wlen;
            end
        end
    end

    assign cache_ce            = r_ren || r_wen;
    assign cache_ren           = r_ren;
    assign cache_wen           = r_wen;
    assign cache_raddr         = r_raddr;
    assign cache_rsel          = r_rsel;
    assign cacher_burst_length = r_rlen;
    assign cache_waddr         = r_waddr;
    assign cache_wsel          = r_wsel;
    assign cachew_burst_length = r_wlen;
    assign cache_wdata         = dc_wdata;
    assign cache_wlast         = w_wbusy && w_wlast;
    assign ic_rdata            = (r_rstate == R_IC) ? rdata_i : '0;
    assign dc_rdata            = (r_rstate == R_DC) ? rdata_i : '0;
    assign ic_rvalid           = w_rbeat && r_rstate == R_IC;
    assign dc_rvalid           = w_rbeat && r_rstate == R_DC;
    assign ic_done             = w_rdone && r_rstate == R_IC;
    assign dc_rdone            = w_rdone && r_rstate == R_DC;
    assign dc_wnext            = w_wbeat;
    assign dc_wdone            = w_wdone;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized bench against a transaction-level model of the arbiter
module tb_mem_req_arbiter;
    logic clk = 1'b0;
    logic resetn, flush, ic_req, dc_rreq, dc_wreq, rdata_valid_i, wdata_resp_i;
    logic [31:0] ic_addr, dc_raddr, dc_waddr, dc_wdata, rdata_i;
    logic [31:0] ic_rdata, dc_rdata, cache_raddr, cache_waddr, cache_wdata;
    logic [3:0] dc_rsel, dc_wsel, cache_rsel, cache_wsel;
    logic [7:0] dc_rlen, dc_wlen, cacher_burst_length, cachew_burst_length;
    logic ic_rvalid, ic_done, dc_rvalid, dc_rdone, dc_wnext, dc_wdone;
    logic cache_ce, cache_ren, cache_wen, cache_wlast;
    int n_vec = 0;
    int n_err = 0;
    // model: read owner (0 none, 1 icache, 2 dcache), beats still owed after the next one
    int m_rown = 0, m_rrem = 0, m_wrem = 0, m_ptr = 0;
    logic m_wbusy = 0, m_ren = 0, m_wen = 0;
    logic [31:0] m_raddr = 0, m_waddr = 0;
    logic [3:0] m_rsel = 0, m_wsel = 0;
    logic [7:0] m_rlen = 0, m_wlen = 0;

    always #5 clk = ~clk;

    mem_req_arbiter dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_rreq(dc_rreq), .dc_raddr(dc_raddr), .dc_rsel(dc_rsel), .dc_rlen(dc_rlen),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_rdone(dc_rdone),
        .dc_wreq(dc_wreq), .dc_waddr(dc_waddr), .dc_wsel(dc_wsel), .dc_wlen(dc_wlen),
        .dc_wdata(dc_wdata), .dc_wnext(dc_wnext), .dc_wdone(dc_wdone),
        .cache_ce(cache_ce), .cache_ren(cache_ren), .cache_wen(cache_wen),
        .cache_raddr(cache_raddr), .cache_waddr(cache_waddr), .cache_rsel(cache_rsel), .cache_wsel(cache_wsel),
        .cacher_burst_length(cacher_burst_length), .cachew_burst_length(cachew_burst_length),
        .cache_wdata(cache_wdata), .cache_wlast(cache_wlast),
        .rdata_i(rdata_i), .rdata_valid_i(rdata_valid_i), .wdata_resp_i(wdata_resp_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // compare this cycle's outputs with the model, then advance the model across the edge
    task automatic cycle();
        logic rv, wv, dc_ok, pref_ic, g_dc, g_ic;
        #1;
        rv = m_rown != 0 && rdata_valid_i && !flush;
        wv = m_wbusy && wdata_resp_i;
        chk("pulses",
            {cache_ce, cache_ren, cache_wen, cache_wlast, ic_rvalid, ic_done, dc_rvalid, dc_rdone, dc_wnext, dc_wdone},
            {m_ren | m_wen, m_ren, m_wen, m_wbusy && m_wrem == 0, rv && m_rown == 1, rv && m_rown == 1 && m_rrem == 0,
             rv && m_rown == 2, rv && m_rown == 2 && m_rrem == 0, wv, wv && m_wrem == 0});
        chk("rd_cmd", {cache_raddr, cache_rsel, cacher_burst_length}, {m_raddr, m_rsel, m_rlen});
        chk("wr_cmd", {cache_waddr, cache_wsel, cachew_burst_length}, {m_waddr, m_wsel, m_wlen});
        chk("wdata", cache_wdata, dc_wdata);
        if (rv) chk("rdata", (m_rown == 1) ? ic_rdata : dc_rdata, rdata_i);
        dc_ok = dc_rreq && !(m_wbusy && m_waddr == dc_raddr);
        pref_ic = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        pref_ic = m_ptr == 1;
`endif
        g_dc = m_rown == 0 && !flush && dc_ok && !(pref_ic && ic_req);
        g_ic = m_rown == 0 && !flush && ic_req && !g_dc;
        if (!resetn) begin
            m_rown = 0; m_rrem = 0; m_wrem = 0; m_ptr = 0;
            m_wbusy = 0; m_ren = 0; m_wen = 0;
            m_raddr = 0; m_waddr = 0; m_rsel = 0; m_wsel = 0; m_rlen = 0; m_wlen = 0;
        end else begin
            m_ren = g_dc || g_ic;
            m_wen = !m_wbusy && dc_wreq;
            if (flush) m_rown = 0;
            else if (rv) begin
                if (m_rrem == 0) m_rown = 0;
                else m_rrem--;
            end else if (g_dc) begin
                m_rown = 2; m_rrem = dc_rlen; m_raddr = dc_raddr; m_rsel = dc_rsel; m_rlen = dc_rlen;
            end else if (g_ic) begin
                m_rown = 1; m_rrem = 7; m_raddr = ic_addr; m_rsel = 4'hf; m_rlen = 8'd7;
            end
            if (g_dc) m_ptr = 1;
            else if (g_ic) m_ptr = 0;
            if (!m_wbusy && dc_wreq) begin
                m_wbusy = 1; m_wrem = dc_wlen; m_waddr = dc_waddr; m_wsel = dc_wsel; m_wlen = dc_wlen;
            end else if (wv) begin
                if (m_wrem == 0) m_wbusy = 0;
                else m_wrem--;
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        resetn = 1; flush = 0; ic_req = 0; dc_rreq = 0; dc_wreq = 0;
        rdata_valid_i = 0; wdata_resp_i = 0;
    endtask

    task automatic drain();
        quiet();
        rdata_valid_i = 1; wdata_resp_i = 1;
        repeat (12) cycle();
        rdata_valid_i = 0; wdata_resp_i = 0;
    endtask

    task automatic rand_inputs();
        logic [31:0] addrs [3] = '{32'h8000_1000, 32'h8000_2000, 32'h1FC0_0000};
        resetn = $urandom_range(199) != 0;
        flush = $urandom_range(31) == 0;
        ic_req = $urandom_range(3) == 0;
        dc_rreq = $urandom_range(2) == 0;
        dc_wreq = $urandom_range(3) == 0;
        ic_addr = addrs[$urandom_range(2)];
        dc_raddr = addrs[$urandom_range(2)];
        dc_waddr = addrs[$urandom_range(2)];
        dc_rsel = 4'($urandom); dc_wsel = 4'($urandom);
        dc_rlen = 8'($urandom_range(3)); dc_wlen = 8'($urandom_range(4));
        dc_wdata = $urandom; rdata_i = $urandom;
        rdata_valid_i = $urandom_range(1) == 1;
        wdata_resp_i = $urandom_range(1) == 1;
    endtask

    initial begin
        quiet();
        resetn = 0;
        ic_addr = 0; dc_raddr = 0; dc_waddr = 0; dc_rsel = 0; dc_wsel = 0;
        dc_rlen = 0; dc_wlen = 0; dc_wdata = 0; rdata_i = 0;
        @(negedge clk);
        repeat (2) cycle();
        quiet();
        // icache refill burst of IC_LEN+1 beats
        ic_req = 1; ic_addr = 32'h1FC0_0000; cycle();
        ic_req = 0; cycle();
        rdata_valid_i = 1;
        repeat (9) begin rdata_i = $urandom; cycle(); end
        quiet();
        // simultaneous icache and dcache reads
        ic_req = 1; dc_rreq = 1; dc_raddr = 32'h8000_2000; dc_rsel = 4'h3; dc_rlen = 0; cycle();
        dc_rreq = 0;
        repeat (14) begin rdata_valid_i = $urandom_range(1) == 1; rdata_i = $urandom; cycle(); end
        drain();
        // write-back followed by a read of the same address
        dc_wreq = 1; dc_waddr = 32'h8000_1000; dc_wsel = 4'hf; dc_wlen = 3; dc_wdata = 32'hA5A5_0001; cycle();
        dc_wreq = 0; dc_rreq = 1; dc_raddr = 32'h8000_1000; dc_rlen = 1;
        repeat (8) begin wdata_resp_i = 1; rdata_valid_i = 1; rdata_i = $urandom; cycle(); end
        drain();
        // flush on the third icache beat, then a dcache read
        ic_req = 1; ic_addr = 32'h1FC0_0040; cycle();
        ic_req = 0; cycle();
        rdata_valid_i = 1; repeat (2) cycle();
        flush = 1; cycle();
        flush = 0; dc_rreq = 1; dc_raddr = 32'h8000_2000; dc_rlen = 2; cycle();
        dc_rreq = 0; repeat (5) cycle();
        drain();
        // reset during a write-back, concurrent with a read to another address
        dc_wreq = 1; dc_waddr = 32'h8000_1000; dc_wlen = 4; cycle();
        dc_wreq = 0; dc_rreq = 1; dc_raddr = 32'h8000_2000; dc_rlen = 3; cycle();
        dc_rreq = 0; resetn = 0; cycle();
        resetn = 1; repeat (2) cycle();
        dc_wreq = 1; dc_waddr = 32'h8000_1000; dc_wlen = 2; cycle();
        dc_wreq = 0; dc_rreq = 1; dc_raddr = 32'h8000_2000; dc_rlen = 2; cycle();
        dc_rreq = 0; drain();
        repeat (3000) begin rand_inputs(); cycle(); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
